// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE has no owner, OWN has one producer granted.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Width of a producer index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of the per-grant beat counter, able to hold 0..max_burst.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start,
// wrapping around to index 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_start,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    // Two passes: upper part [start..N-1] first, then the wrapped part [0..start-1].
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!o_found && i_req[j] && (j >= int'(i_start))) begin
                o_found = 1'b1;
                o_idx   = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!o_found && i_req[j] && (j < int'(i_start))) begin
                o_found = 1'b1;
                o_idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ
// producers. Grants bursts of up to MAX_BURST beats, honours fifo_full and
// hands over ownership without idle cycles.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 4,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id
);

    localparam int unsigned      CNT_W     = cnt_width(MAX_BURST);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  w_owner_nxt;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  w_last_grant_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;

    logic [ID_W-1:0]       w_idle_start;
    logic                  w_idle_found;
    logic [ID_W-1:0]       w_idle_idx;
    logic [ID_W-1:0]       w_rel_start;
    logic [NUM_REQ-1:0]    w_rel_req;
    logic                  w_rel_found;
    logic [ID_W-1:0]       w_rel_idx;
    logic                  w_own_valid;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_accept;
    logic                  w_release;

    // Successor index modulo NUM_REQ.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    // Scan starts just after the last grant, so the last grantee is scanned last.
    assign w_idle_start = next_id(r_last_grant);
    // At release the pointer becomes the current owner, so scanning starts after it.
    assign w_rel_start  = next_id(r_owner);

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_idle_pick (
        .i_req   (req_valid),
        .i_start (w_idle_start),
        .o_found (w_idle_found),
        .o_idx   (w_idle_idx)
    );

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rel_pick (
        .i_req   (w_rel_req),
        .i_start (w_rel_start),
        .o_found (w_rel_found),
        .o_idx   (w_rel_idx)
    );

    // Select the owner's valid/data and build the request vector with the owner masked.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = '0;
        w_rel_req   = req_valid;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == ID_W'(i)) begin
                w_own_valid  = req_valid[i];
                w_own_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_rel_req[i] = 1'b0;
            end
        end
    end

    assign w_accept  = (r_state == OWN) && w_own_valid && !fifo_full;
    assign w_release = (r_state == OWN) &&
                       (!w_own_valid || (w_accept && (r_beat_cnt == LAST_BEAT)));

    // State, owner, pointer and beat counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_grant <= LAST_ID;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    // Next-state logic and outputs decoded from registered state and live inputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        grant_valid      = 1'b0;
        grant_id         = '0;
        req_ready        = '0;
        fifo_wr_en       = 1'b0;
        fifo_wr_data     = '0;

        unique case (r_state)
            IDLE: begin
                if (w_idle_found) begin
                    w_state_nxt    = OWN;
                    w_owner_nxt    = w_idle_idx;
                    w_beat_cnt_nxt = '0;
                end
            end

            OWN: begin
                grant_valid  = 1'b1;
                grant_id     = r_owner;
                fifo_wr_en   = w_accept;
                fifo_wr_data = w_own_data;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (r_owner == ID_W'(i)) && !fifo_full;
                end

                if (w_release) begin
                    w_last_grant_nxt = r_owner;
                    w_beat_cnt_nxt   = '0;
                    if (w_rel_found) begin
                        w_owner_nxt = w_rel_idx;
                    end else if (!w_own_valid) begin
                        w_state_nxt = IDLE;
                    end
                    // Otherwise only the owner is still valid: it keeps the grant
                    // with a fresh burst, no bubble.
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a behavioural
// round-robin/burst model and a queue-based FIFO model (8 entries).
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          grant_valid;
    logic [1:0]    grant_id;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_own;
    int m_owner;
    int m_last;
    int m_beats;
    int fifo_q[$];

    // Observed-write logs
    int wr_log_data[$];
    int wr_log_id[$];
    int wr_log_cyc[$];
    int cyc = 0;
    logic [N-1:0] s_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // First valid index strictly after p, wrapping; p itself comes last.
    function automatic int pick_after(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (p + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] rand_valid();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v = {v[N-2:0], ($urandom_range(0, 9) < 7)};
        return v;
    endfunction

    task automatic m_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    task automatic clear_logs();
        wr_log_data.delete();
        wr_log_id.delete();
        wr_log_cyc.delete();
    endtask

    task automatic check_outputs();
        logic [1:0]    o;
        logic [N-1:0]  exp_ready;
        logic          exp_wr;
        logic [DW-1:0] exp_data;
        o         = m_owner[1:0];
        exp_ready = (m_own && !fifo_full) ? (4'b0001 << o) : 4'b0000;
        exp_wr    = m_own && req_valid[o] && !fifo_full;
        exp_data  = req_data[o*DW +: DW];
        chk("grant_valid", grant_valid, m_own);
        if (m_own) chk("grant_id", grant_id, m_owner);
        chk("req_ready", req_ready, exp_ready);
        chk("wr_en", fifo_wr_en, exp_wr);
        if (exp_wr) chk("wr_data", fifo_wr_data, exp_data);
    endtask

    task automatic check_reset_outputs();
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
    endtask

    // Apply one clock edge to the model and FIFO, using inputs seen at the edge.
    task automatic model_update(input bit rd);
        logic [1:0] o;
        bit         acc;
        int         nxt;
        o   = m_owner[1:0];
        acc = m_own && req_valid[o] && !fifo_full;
        if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (acc) fifo_q.push_back(int'(req_data[o*DW +: DW]));
        if (!m_own) begin
            if (req_valid != '0) begin
                m_owner = pick_after(req_valid, m_last);
                m_beats = 0;
                m_own   = 1'b1;
            end
        end else begin
            if (acc) m_beats++;
            if ((acc && m_beats == MB) || !req_valid[o]) begin
                m_last  = m_owner;
                m_beats = 0;
                nxt     = pick_after(req_valid & ~(4'b0001 << o), m_owner);
                if (nxt >= 0) m_owner = nxt;
                else if (!req_valid[o]) m_own = 1'b0;
            end
        end
    endtask

    // One cycle: outputs checked at negedge+1, model advanced at posedge; returns posedge+1.
    task automatic step(input bit rd);
        fifo_full = (fifo_q.size() >= DEPTH);
        @(negedge clk);
        #1;
        check_outputs();
        s_ready = req_ready;
        if (fifo_wr_en === 1'b1) begin
            wr_log_data.push_back(int'(fifo_wr_data));
            wr_log_id.push_back(int'(grant_id));
            wr_log_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_update(rd);
        cyc++;
        #1;
    endtask

    // Async reset asserted between edges; returns at posedge+1 with reset released.
    task automatic do_reset(input int hold, input bit rnd);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
        check_reset_outputs();
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            if (rnd) begin
                req_valid = rand_valid();
                req_data  = 16'($urandom);
            end
            @(negedge clk);
            #1;
            check_reset_outputs();
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int val;
        int base;

        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        m_reset();

        // Reset with random valids, then producer 0 wins first.
        do_reset(2, 1'b1);
        fifo_q.delete();
        req_valid = 4'b1111;
        step(1'b0);
        chk("first_grant_valid", grant_valid, 1);
        chk("first_grant_id", grant_id, 0);

        // Single producer 2 streams 1..6 with same-owner re-grant.
        do_reset(1, 1'b0);
        fifo_q.delete();
        clear_logs();
        val       = 1;
        req_valid = 4'b0100;
        req_data  = 16'($urandom);
        req_data[11:8] = 4'(val);
        for (int c = 0; c < 12; c++) begin
            step(1'b0);
            if (c == 0) chk("s2_grant_id", grant_id, 2);
            if (s_ready[2] && req_valid[2]) val++;
            req_data  = 16'($urandom);
            req_data[11:8] = 4'(val);
            req_valid = (val <= 6) ? 4'b0100 : 4'b0000;
        end
        chk("s2_count", wr_log_data.size(), 6);
        for (int i = 0; i < wr_log_data.size() && i < 6; i++) begin
            chk("s2_data", wr_log_data[i], i + 1);
            chk("s2_id", wr_log_id[i], 2);
        end
        if (wr_log_cyc.size() >= 6) chk("s2_no_bubble", wr_log_cyc[5] - wr_log_cyc[0], 5);

        // All four valid: fill to full, then drain one per cycle.
        do_reset(1, 1'b0);
        fifo_q.delete();
        clear_logs();
        req_valid = 4'b1111;
        for (int c = 0; c < 14; c++) begin
            req_data = 16'($urandom);
            step(1'b0);
        end
        chk("s3_beats_to_full", wr_log_data.size(), 8);
        for (int c = 0; c < 24; c++) begin
            req_data = 16'($urandom);
            step(1'b1);
        end
        chk("s3_enough_writes", (wr_log_id.size() >= 20), 1);
        for (int i = 0; i < wr_log_id.size() && i < 20; i++) begin
            chk("s3_grant_seq", wr_log_id[i], (i / 4) % 4);
        end

        // Producer 1 owns while FIFO fills; one read lets exactly one beat in.
        do_reset(1, 1'b0);
        fifo_q.delete();
        clear_logs();
        req_valid = 4'b0010;
        for (int c = 0; c < 14; c++) begin
            req_data = 16'($urandom);
            step(1'b0);
        end
        chk("s4_fill", wr_log_data.size(), 8);
        chk("s4_stall_ready", req_ready, 0);
        chk("s4_stall_wr", fifo_wr_en, 0);
        base = wr_log_data.size();
        step(1'b1);
        for (int c = 0; c < 4; c++) step(1'b0);
        chk("s4_one_beat", wr_log_data.size() - base, 1);

        // Producer 3 drops after 2 beats while producer 0 waits.
        do_reset(1, 1'b0);
        fifo_q.delete();
        clear_logs();
        req_valid = 4'b1000;
        req_data  = 16'($urandom);
        step(1'b0);
        req_valid = 4'b1001;
        step(1'b0);
        step(1'b0);
        req_valid = 4'b0001;
        step(1'b0);
        chk("s5_regrant_valid", grant_valid, 1);
        chk("s5_regrant_id", grant_id, 0);
        step(1'b0);
        base = 0;
        foreach (wr_log_id[i]) if (wr_log_id[i] == 3) base++;
        chk("s5_p3_beats", base, 2);

        // Reset mid-burst of producer 1, then restart with producers 1 and 2 valid.
        do_reset(1, 1'b0);
        fifo_q.delete();
        clear_logs();
        req_valid = 4'b0010;
        req_data  = 16'($urandom);
        step(1'b0);
        step(1'b0);
        do_reset(1, 1'b0);
        req_valid = 4'b0110;
        step(1'b0);
        chk("s6_grant_valid", grant_valid, 1);
        chk("s6_grant_id", grant_id, 1);
        step(1'b0);

        // Random traffic with random reads and occasional resets.
        do_reset(1, 1'b1);
        fifo_q.delete();
        for (int c = 0; c < 3000; c++) begin
            req_valid = rand_valid();
            req_data  = 16'($urandom);
            if (c % 700 == 699) do_reset(1, 1'b1);
            step($urandom_range(0, 9) < 4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
